// File: rtl/sub_pkg.sv
// Shared types and constants for the pipelined 8-bit carry-select subtractor.
//   nibble_t : 4-bit nibble
//   byte_t   : 8-bit operand/result
//   s2_t     : stage-2 register bundle (low nibble result plus both high-nibble candidates)
//   LATENCY  : edges from input acceptance to visible out_valid, counting the accepting edge
package sub_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [7:0] byte_t;

  typedef struct packed {
    nibble_t lo_diff;
    logic    c_lo;
    nibble_t hi_diff0;
    logic    c_hi0;
    nibble_t hi_diff1;
    logic    c_hi1;
    logic    a7;
    logic    b7;
  } s2_t;

  localparam int unsigned LATENCY = 3;

endpackage

// File: rtl/eight_bit_select_subtractor_if.sv
// Operand/result handshake bundle for eight_bit_select_subtractor.
//   in_valid/in_ready   : operand handshake (A, B, Bin)
//   out_valid/out_ready : result handshake (diff, borrow_out, overflow)
//   master : producer of operands / consumer of results
//   slave  : the subtractor
interface eight_bit_select_subtractor_if;
  import sub_pkg::*;

  logic  in_valid;
  logic  in_ready;
  byte_t A;
  byte_t B;
  logic  Bin;
  logic  out_valid;
  logic  out_ready;
  byte_t diff;
  logic  borrow_out;
  logic  overflow;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, diff, borrow_out, overflow
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, diff, borrow_out, overflow
  );

endinterface

// File: rtl/nibble_sub.sv
// Combinational 4-bit subtract cell in two's-complement form: {cout, d} = a + ~b + cin.
//   a, b : nibble operands
//   cin  : carry in (1 means "no borrow")
//   d    : 4-bit result
//   cout : carry out (1 means "no borrow")
module nibble_sub
  import sub_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    cin,
  output nibble_t d,
  output logic    cout
);

  logic [4:0] sum;

  assign sum  = {1'b0, a} + {1'b0, ~b} + {4'b0000, cin};
  assign d    = sum[3:0];
  assign cout = sum[4];

endmodule

// File: rtl/eight_bit_select_subtractor.sv
// Pipelined 8-bit carry-select subtractor: diff = A - B - Bin (mod 256).
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset, flushes all in-flight operations
//   bus     : slave side of the operand/result handshake
// Three stages shift together on adv = !out_valid || out_ready:
//   S1 registers operands, S2 registers the low nibble and both high-nibble candidates,
//   S3 selects the high nibble with the low carry and registers the flags.
module eight_bit_select_subtractor
  import sub_pkg::*;
(
  input logic                          clk,
  input logic                          reset_n,
  eight_bit_select_subtractor_if.slave bus
);

  logic adv;

  // S1
  byte_t a_q, b_q;
  logic  bin_q, v1_q;

  // S2
  s2_t  s2_d, s2_q;
  logic v2_q;

  // S3
  byte_t diff_d, diff_q;
  logic  borrow_d, borrow_q;
  logic  ovf_d, ovf_q;
  logic  v3_q;

  // Bubbles are not collapsed: a stall freezes every stage at once.
  assign adv         = !v3_q || bus.out_ready;
  assign bus.in_ready = adv;

  nibble_sub u_lo (
    .a   (a_q[3:0]),
    .b   (b_q[3:0]),
    .cin (!bin_q),
    .d   (s2_d.lo_diff),
    .cout(s2_d.c_lo)
  );

  nibble_sub u_hi0 (
    .a   (a_q[7:4]),
    .b   (b_q[7:4]),
    .cin (1'b0),
    .d   (s2_d.hi_diff0),
    .cout(s2_d.c_hi0)
  );

  nibble_sub u_hi1 (
    .a   (a_q[7:4]),
    .b   (b_q[7:4]),
    .cin (1'b1),
    .d   (s2_d.hi_diff1),
    .cout(s2_d.c_hi1)
  );

  assign s2_d.a7 = a_q[7];
  assign s2_d.b7 = b_q[7];

  always_comb begin
    nibble_t hi;
    logic    c_hi;
    hi       = s2_q.hi_diff0;
    c_hi     = s2_q.c_hi0;
    if (s2_q.c_lo) begin
      hi   = s2_q.hi_diff1;
      c_hi = s2_q.c_hi1;
    end
    diff_d   = {hi, s2_q.lo_diff};
    borrow_d = !c_hi;
    ovf_d    = (s2_q.a7 != s2_q.b7) && (hi[3] != s2_q.a7);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      bin_q    <= 1'b0;
      v1_q     <= 1'b0;
      s2_q     <= '0;
      v2_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      v3_q     <= 1'b0;
    end else if (adv) begin
      a_q      <= bus.A;
      b_q      <= bus.B;
      bin_q    <= bus.Bin;
      // in_ready equals adv, so in_valid alone marks a transfer here
      v1_q     <= bus.in_valid;
      s2_q     <= s2_d;
      v2_q     <= v1_q;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      v3_q     <= v2_q;
    end
  end

  assign bus.out_valid  = v3_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_eight_bit_select_subtractor.sv
// Directed self-checking bench for eight_bit_select_subtractor.
module tb_eight_bit_select_subtractor;
  import sub_pkg::*;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  eight_bit_select_subtractor_if bus ();

  eight_bit_select_subtractor dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {borrow, overflow, diff} computed with plain 9-bit arithmetic
  function automatic logic [9:0] ref_sub(input logic [7:0] a, input logic [7:0] b,
                                         input logic bin);
    logic [8:0] t;
    t = {1'b0, a} - {1'b0, b} - {8'h00, bin};
    return {t[8], ((a[7] != b[7]) && (t[7] != a[7])), t[7:0]};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Single operation, pipeline empty, out_ready=1; checks the exact latency.
  task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic [7:0] ed, input logic eb,
                         input logic eo);
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.Bin      = bin;
    bus.in_valid = 1'b1;
    #1;
    check({tag, " in_ready"}, {9'd0, bus.in_ready}, 10'd1);
    for (int e = 1; e <= int'(LATENCY); e++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (e < int'(LATENCY)) check({tag, " early valid"}, {9'd0, bus.out_valid}, 10'd0);
    end
    check({tag, " out_valid"}, {9'd0, bus.out_valid}, 10'd1);
    check({tag, " result"}, {bus.borrow_out, bus.overflow, bus.diff}, {eb, eo, ed});
    @(negedge clk);
    check({tag, " drained"}, {9'd0, bus.out_valid}, 10'd0);
  endtask

  logic [7:0] sa   [8];
  logic [7:0] sb   [8];
  logic       sbin [8];
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [9:0] hold;
  int         next_op;

  initial begin
    total = 0;
    bad   = 0;
    sa    = '{8'h00, 8'hFF, 8'h10, 8'h80, 8'h7F, 8'h01, 8'hC3, 8'h55};
    sb    = '{8'h01, 8'hFF, 8'h20, 8'h7F, 8'h80, 8'h00, 8'h3C, 8'hAA};
    sbin  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = 8'h00;
    bus.B         = 8'h00;
    bus.Bin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst out_valid", {9'd0, bus.out_valid}, 10'd0);
    check("rst flags+diff", {bus.borrow_out, bus.overflow, bus.diff}, 10'h000);
    check("rst in_ready", {9'd0, bus.in_ready}, 10'd1);
    reset_n = 1'b1;

    // Directed arithmetic with hand-computed results
    run_one("50-30",   8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0);
    run_one("30-50",   8'h30, 8'h50, 1'b0, 8'hE0, 1'b1, 1'b0);
    run_one("00-00-1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_one("80-01",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_one("7F-FF",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_one("A5-5A-1", 8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1);
    run_one("5A-5A-1", 8'h5A, 8'h5A, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Back-to-back stream: result k visible at negedge k+LATENCY
    for (int m = 0; m < 12; m++) begin
      @(negedge clk);
      if (m >= int'(LATENCY) && m < int'(LATENCY) + 8) begin
        check($sformatf("stream valid %0d", m), {9'd0, bus.out_valid}, 10'd1);
        check($sformatf("stream res %0d", m), {bus.borrow_out, bus.overflow, bus.diff},
              ref_sub(sa[m-int'(LATENCY)], sb[m-int'(LATENCY)], sbin[m-int'(LATENCY)]));
      end else if (m > 0) begin
        check($sformatf("stream idle %0d", m), {9'd0, bus.out_valid}, 10'd0);
      end
      if (m < 8) begin
        bus.A        = sa[m];
        bus.B        = sb[m];
        bus.Bin      = sbin[m];
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
    end

    // Backpressure: 5-cycle stall with the pipeline full, handshake monitor on both sides
    next_op = 0;
    hold    = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 3 && c < 8);
      bus.in_valid  = (next_op < 6);
      bus.A         = sa[next_op % 8] ^ 8'h3C;
      bus.B         = sb[next_op % 8];
      bus.Bin       = sbin[(next_op + 1) % 8];
      #1;
      if (c == 3) hold = {bus.borrow_out, bus.overflow, bus.diff};
      if (c >= 3 && c < 8) begin
        check($sformatf("stall in_ready %0d", c), {9'd0, bus.in_ready}, 10'd0);
        check($sformatf("stall valid %0d", c), {9'd0, bus.out_valid}, 10'd1);
        check($sformatf("stall hold %0d", c), {bus.borrow_out, bus.overflow, bus.diff}, hold);
      end
      if (bus.out_valid && bus.out_ready) got_q.push_back({bus.borrow_out, bus.overflow,
                                                           bus.diff});
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_sub(bus.A, bus.B, bus.Bin));
        next_op++;
      end
    end
    bus.in_valid = 1'b0;
    check("stall accepted", 10'(exp_q.size()), 10'd6);
    check("stall delivered", 10'(got_q.size()), 10'd6);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check("stall order", got_q.pop_front(), exp_q.pop_front());
    end

    // Mid-stream reset with one result showing and two operations in flight
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.A         = 8'hF0 - 8'(c);
      bus.B         = 8'h0F;
      bus.Bin       = 1'b0;
      bus.in_valid  = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("pre-rst valid", {9'd0, bus.out_valid}, 10'd1);
    check("pre-rst diff", {2'b00, bus.diff}, 10'h0E1);
    reset_n = 1'b0;
    #1;
    check("mid-rst valid", {9'd0, bus.out_valid}, 10'd0);
    check("mid-rst flags+diff", {bus.borrow_out, bus.overflow, bus.diff}, 10'h000);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("post-rst idle %0d", c), {9'd0, bus.out_valid}, 10'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eight_bit_select_subtractor.md
# eight_bit_select_subtractor

Pipelined 8-bit carry-select subtractor computing A − B − Bin, with a valid/ready handshake on both sides and signed-overflow and borrow flags. It is the inverse-operation companion to the team's pipelined 8-bit carry-select adder. Internally it reuses the same nibble-split, dual-candidate-select structure in two's-complement form (A + ~B + ~Bin). It sits in the datapath beside the adder and adds elastic backpressure, so it can feed consumers that stall.

## Interface
- No parameters; widths are fixed at 8 bits total, split into two 4-bit nibbles.
- clk  in  1  Single clock; all registers update on its rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- in_valid  in  1  Operands A, B, Bin are valid this cycle.
- in_ready  out  1  Block accepts operands this cycle. Combinational: in_ready = !out_valid || out_ready.
- A  in  8  Minuend.
- B  in  8  Subtrahend.
- Bin  in  1  Borrow in.
- out_valid  out  1  Result fields are valid.
- out_ready  in  1  Consumer accepts the result this cycle.
- diff  out  8  Result (A − B − Bin) mod 256.
- borrow_out  out  1  1 when the unsigned result A < B + Bin.
- overflow  out  1  Signed overflow: (A[7] != B[7]) && (diff[7] != A[7]).

## Operation
- Input transfer occurs when in_valid && in_ready.
- Output transfer occurs when out_valid && out_ready.
- Global advance signal: adv = !out_valid || out_ready. All three stages shift together when adv=1 and hold otherwise.
- Bubbles are not collapsed during a stall. This is acceptable because throughput is 1 per cycle whenever out_ready=1.
- Stage 1 (S1) registers A, B, Bin and v1 = in_valid && in_ready.
- Stage 2 (S2):
  - Computes the lower nibble A[3:0] + ~B[3:0] + !Bin, giving a 4-bit diff and carry c_lo.
  - Computes two upper-nibble candidates A[7:4] + ~B[7:4] + {0, 1}, giving diffs and carries.
  - Registers all of these, plus the sign bits A[7] and B[7], and v2.
- Stage 3 (S3):
  - Selects the upper candidate using c_lo.
  - Registers diff, borrow_out = !c_hi_selected, the overflow flag, and out_valid.
- While adv=0, every stage register holds its value. in_ready=0 in that state, so in_valid is ignored.
- Simultaneous output transfer and input transfer in the same cycle is legal and required. The pipeline shifts and both handshakes complete.
- Mid-stream reset: when reset_n is asserted, all in-flight operations are discarded immediately and asynchronously. No partial result appears after reset_n is released.
- Arithmetic:
  - All nibble math is 5-bit (4-bit sum plus carry).
  - The 8-bit result wraps modulo 256.
  - Bin=1 with A=B gives diff=0xFF and borrow_out=1.

## Timing
- Reset values: out_valid=0, diff=0x00, borrow_out=0, overflow=0, and all internal valid bits 0. in_ready therefore reads 1 while reset_n is low, but no transfer is recorded.
- Latency: an input transferred at rising edge N produces out_valid=1 after edge N+2, i.e. it is visible in the cycle following edge N+2. This assumes out_ready stays 1.
- Throughput: one operation per cycle while out_ready=1.
- Stall: if out_ready=0 while out_valid=1, then:
  - out_valid, diff, borrow_out and overflow stay stable until the transfer completes.
  - in_ready drops combinationally in the same cycle.
- No combinational path from A, B, Bin or in_valid to any output. The only combinational path is out_ready → in_ready.

## Structure
- Shared package sub_pkg holds:
  - typedef nibble_t (logic [3:0]);
  - typedef byte_t (logic [7:0]);
  - typedef struct s2_t for the S2 register bundle: lo_diff, c_lo, hi_diff0, c_hi0, hi_diff1, c_hi1, a7, b7;
  - localparam LATENCY = 3.
- One combinational sub-module, nibble_sub: inputs a[3:0], b[3:0], cin; outputs d[3:0], cout; computes a + ~b + cin. Three instances are used in S2.
- Top level contains the stage registers, the adv/handshake logic and the S3 select mux.

## Test plan
- After reset, drive A=0x50, B=0x30, Bin=0 with out_ready=1. Required: diff=0x20, borrow_out=0, overflow=0, and out_valid asserted exactly 3 edges after acceptance.
- A=0x30, B=0x50, Bin=0 → diff=0xE0, borrow_out=1, overflow=0. A=0x00, B=0x00, Bin=1 → diff=0xFF, borrow_out=1, overflow=0.
- Signed overflow: A=0x80, B=0x01, Bin=0 → diff=0x7F, overflow=1, borrow_out=0. A=0x7F, B=0xFF → diff=0x80, overflow=1, borrow_out=1.
- Stream 8 back-to-back operands with out_ready=1. Required: 8 results in order on 8 consecutive cycles, starting at edge +3.
- Hold out_ready=0 for 5 cycles with the pipeline full. Required: in_ready=0, outputs stable, and no operation lost or duplicated once out_ready returns to 1.
- Assert reset_n=0 with 2 operations in flight. Required: out_valid=0 and diff=0x00 immediately, and no stale result after release.
